tt_sweep_capture: RTL and testbench
===================================

# tt_sweep_capture

Sequential truth-table characterizer: drives every input vector into a 4-input combinational gate netlist, samples the single output after a settle delay, and assembles the 16-bit truth-table word in the same hex convention used for design names (e.g. 0x10C9). It is the read-back end of the synthesis flow. The synthesized gate consumes a truth table and implements it; this block recovers the truth table from the gate and checks it against the expected value. It sits in the verification/emulation harness between a sweep controller and the gate under test.

## Interface
- N_IN, 4: gate input count; TT_W = 2**N_IN.
- SETTLE, 2: cycles each vector is held before sampling; legal range 1..255.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a sweep; accepted only in IDLE.
- expected  in  TT_W  reference truth table; captured on the accepted start.
- stim  out  N_IN  gate inputs; stim[N_IN-1] drives gate input 0 (MSB of vector index), stim[0] drives input N_IN-1.
- resp  in  1  gate output.
- busy  out  1  high from the cycle after an accepted start through the last SAMPLE.
- done  out  1  one-cycle pulse when the result is valid.
- tt  out  TT_W  captured truth table; held until the next done.
- match  out  1  tt == expected; valid with done, held.
- diff  out  TT_W  tt ^ expected; valid with done, held.

## Operation
- Bit convention: for vector index i (gate input 0 is MSB), tt[TT_W-1-i] = f(i). Index 0 therefore lands in the hex MSB.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
  - IDLE: if start is high, load idx=0, cnt=0, exp_q=expected, and clear the work register; go to DRIVE.
  - DRIVE: stim=idx. cnt increments each cycle. At cnt==SETTLE-1, go to SAMPLE.
  - SAMPLE: stim still = idx. Write work[TT_W-1-idx] = resp. If idx==TT_W-1, go to DONE. Otherwise idx++, cnt=0, go to DRIVE.
  - DONE: done=1. tt is loaded from work, with the SAMPLE write forwarded for the final bit. match and diff are computed from that value and exp_q. Go to IDLE.
- idx is N_IN+1 bits wide so there is no wrap. The terminal test uses idx==TT_W-1 and never overflow.
- start in DRIVE, SAMPLE or DONE is ignored. The request is not queued.
- expected may change during a sweep. Only the value captured at start is used.
- tt, match and diff keep their previous values for the whole sweep and change only in the DONE cycle.
- Reset values: state IDLE, stim 0, busy 0, done 0, tt 0, match 0, diff 0, idx 0, cnt 0.
- rst asserted mid-sweep: everything returns to its reset value on the next edge. No done is produced and the partial result is discarded.

## Timing
- Each vector takes SETTLE+1 cycles: SETTLE DRIVE cycles plus 1 SAMPLE cycle.
- If start is accepted at edge 0, stim=0 becomes visible after edge 0.
- resp for vector i is sampled at edge (i+1)(SETTLE+1).
- done is high during cycle TT_W(SETTLE+1)+1, i.e. after edge TT_W(SETTLE+1).
  - SETTLE=2, N_IN=4: done after edge 48.
- Back-to-back: the earliest next start is accepted in the IDLE cycle that follows DONE.
- stim changes only on DRIVE entry, so each vector is stable for exactly SETTLE+1 cycles.
- All outputs are registered. resp and start feed flops only.

## Structure
- Package tt_pkg:
  - state enum (IDLE/DRIVE/SAMPLE/DONE);
  - localparams for N_IN default, TT_W and the SETTLE range;
  - function tt_bit_pos(idx) returning TT_W-1-idx.
- Sub-module tt_settle_timer: loadable down-counter with a terminal-count output, parameterized by SETTLE. It is reused by the stimulus sequencer.
- The top level holds the FSM, idx, the work and result registers, and the compare logic.

## Test plan
- DUT = 4-input gate for 0x10C9, expected=0x10C9, SETTLE=2, start pulse → done after edge 48, tt=0x10C9, match=1, diff=0x0000.
- Same DUT, expected=0x10C8 → tt=0x10C9, match=0, diff=0x0001.
- resp tied 0 then tied 1, SETTLE=1 → tt=0x0000 then 0xFFFF, done after edge 32, stim sequence 0..15 with each value held 2 cycles.
- start held high for the entire sweep → exactly one done; the second sweep begins at the IDLE cycle after DONE.
- rst pulsed at edge 20 of a sweep → after the next edge: stim=0, busy=0, no done, tt=0. A fresh start then yields the correct full result.
- Bench DUT = resp is stim[3] (gate input 0) → tt=0x00FF, confirming the MSB-first bit convention.

Source files
------------

// File: rtl/tt_sweep_capture_pkg.sv
// Shared types and constants for the truth-table sweep capture block.
// Bit convention: vector index 0 (input 0 as MSB) lands in the hex MSB.
package tt_pkg;

  localparam int N_IN_DEF   = 4;
  localparam int TT_W       = 2 ** N_IN_DEF;
  localparam int SETTLE_DEF = 2;
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic int unsigned tt_bit_pos(
    input int unsigned idx,
    input int unsigned tt_w = TT_W
  );
    return tt_w - 1 - idx;
  endfunction

endpackage

// File: rtl/tt_sweep_capture_if.sv
// Sweep request/result bundle plus the gate-under-test stimulus/response.
// master: sweep controller and gate side; slave: the capture block.
interface tt_sweep_capture_if #(
  parameter int N_IN = 4
);
  localparam int TT_W = 2 ** N_IN;

  logic              start;
  logic [TT_W-1:0]   expected;
  logic [N_IN-1:0]   stim;
  logic              resp;
  logic              busy;
  logic              done;
  logic [TT_W-1:0]   tt;
  logic              match;
  logic [TT_W-1:0]   diff;

  modport master (
    output start, expected, resp,
    input  stim, busy, done, tt, match, diff
  );

  modport slave (
    input  start, expected, resp,
    output stim, busy, done, tt, match, diff
  );

endinterface

// File: rtl/tt_sweep_capture_settle_timer.sv
// Loadable down-counter; tc is high once the count reaches zero.
// Loading SETTLE-1 gives exactly SETTLE cycles up to and including tc.
module tt_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  logic [7:0] cnt;

  assign tc = (cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= 8'(SETTLE - 1);
    end else if (en && !tc) begin
      cnt <= cnt - 8'd1;
    end
  end

endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps all gate input vectors, samples the output after a settle time
// and assembles the truth-table word, compared against a captured reference.
module tt_sweep_capture
  import tt_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input logic              clk,
  input logic              rst,
  tt_sweep_capture_if.slave bus
);

  localparam int TW = 2 ** N_IN;
  localparam int IW = N_IN + 1;

  localparam logic [1:0] IDLE   = 2'(ST_IDLE);
  localparam logic [1:0] DRIVE  = 2'(ST_DRIVE);
  localparam logic [1:0] SAMPLE = 2'(ST_SAMPLE);
  localparam logic [1:0] DONE   = 2'(ST_DONE);

  localparam logic [IW-1:0] LAST = IW'(TW - 1);

  logic [1:0]      state;
  logic [IW-1:0]   idx;
  logic [TW-1:0]   work;
  logic [TW-1:0]   work_nxt;
  logic [TW-1:0]   exp_q;
  logic [N_IN-1:0] pos;
  logic            last;
  logic            tmr_load;
  logic            tmr_en;
  logic            tmr_tc;

  assign last = (idx == LAST);
  assign pos  = N_IN'(tt_bit_pos(32'(idx), TW));

  // Final bit is forwarded so tt is complete in the DONE cycle.
  always_comb begin
    work_nxt      = work;
    work_nxt[pos] = bus.resp;
  end

  always_comb begin
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    case (state)
      IDLE:    tmr_load = bus.start;
      DRIVE:   tmr_en   = 1'b1;
      SAMPLE:  tmr_load = !last;
      default: tmr_load = 1'b0;
    endcase
  end

  tt_settle_timer #(
    .SETTLE(SETTLE)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .en   (tmr_en),
    .tc   (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      work      <= '0;
      exp_q     <= '0;
      bus.stim  <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.tt    <= '0;
      bus.match <= 1'b0;
      bus.diff  <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            idx      <= '0;
            work     <= '0;
            exp_q    <= bus.expected;
            bus.stim <= '0;
            bus.busy <= 1'b1;
            state    <= DRIVE;
          end
        end
        DRIVE: begin
          if (tmr_tc) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          work <= work_nxt;
          if (last) begin
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
            bus.tt    <= work_nxt;
            bus.match <= (work_nxt == exp_q);
            bus.diff  <= work_nxt ^ exp_q;
            state     <= DONE;
          end else begin
            idx      <= idx + 1'b1;
            bus.stim <= bus.stim + 1'b1;
            state    <= DRIVE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Directed bench for tt_sweep_capture with SETTLE=2 and SETTLE=1 instances.
module tb_tt_sweep_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  tt_sweep_capture_if #(.N_IN(4)) bus2 ();
  tt_sweep_capture_if #(.N_IN(4)) bus1 ();

  tt_sweep_capture #(.N_IN(4), .SETTLE(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  tt_sweep_capture #(.N_IN(4), .SETTLE(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // gate models: 0 table, 1 tied 0, 2 tied 1, 3 resp = stim[3]
  int          mode1 = 0;
  int          mode2 = 0;
  logic [15:0] gt1 = '0;
  logic [15:0] gt2 = '0;

  function automatic logic gate(int m, logic [15:0] g, logic [3:0] st);
    logic [3:0] p;
    p = 4'd15 - st;
    case (m)
      0: return g[p];
      1: return 1'b0;
      2: return 1'b1;
      default: return st[3];
    endcase
  endfunction

  assign bus2.resp = gate(mode2, gt2, bus2.stim);
  assign bus1.resp = gate(mode1, gt1, bus1.stim);

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] g_tt(int s);
    return (s == 1) ? bus1.tt : bus2.tt;
  endfunction
  function automatic logic [15:0] g_diff(int s);
    return (s == 1) ? bus1.diff : bus2.diff;
  endfunction
  function automatic logic g_match(int s);
    return (s == 1) ? bus1.match : bus2.match;
  endfunction
  function automatic logic g_done(int s);
    return (s == 1) ? bus1.done : bus2.done;
  endfunction
  function automatic logic g_busy(int s);
    return (s == 1) ? bus1.busy : bus2.busy;
  endfunction
  function automatic logic [3:0] g_stim(int s);
    return (s == 1) ? bus1.stim : bus2.stim;
  endfunction

  task automatic drive(int s, logic st, logic [15:0] e);
    if (s == 1) begin
      bus1.start    = st;
      bus1.expected = e;
    end else begin
      bus2.start    = st;
      bus2.expected = e;
    end
  endtask

  // Start at edge 0, then track stim/busy/tt-hold and done timing.
  task automatic sweep(input int s, input logic [15:0] e,
                       output int done_at, output int done_cnt,
                       output int err);
    int sw;
    logic [15:0] tt0;
    sw       = 16 * (s + 1);
    done_at  = -1;
    done_cnt = 0;
    err      = 0;
    tt0      = g_tt(s);
    drive(s, 1'b1, e);
    @(posedge clk); #1;
    drive(s, 1'b0, ~e);
    for (int k = 1; k <= sw + 4; k++) begin
      @(posedge clk); #1;
      if (k < sw) begin
        if (g_stim(s) !== 4'(k / (s + 1))) err++;
        if (g_busy(s) !== 1'b1) err++;
        if (g_tt(s) !== tt0) err++;
      end
      if (k == sw && g_busy(s) !== 1'b0) err++;
      if (g_done(s) === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
    end
  endtask

  typedef struct {
    int          s;
    int          mode;
    logic [15:0] gt;
    logic [15:0] exp;
    logic [15:0] tt;
    logic        m;
    logic [15:0] d;
  } vec_t;

  vec_t vt[7];

  initial begin
    int da, dc, er, dn;
    logic b49, b50;
    logic [3:0] s50;

    vt[0] = '{2, 0, 16'h10C9, 16'h10C9, 16'h10C9, 1'b1, 16'h0000};
    vt[1] = '{2, 0, 16'h10C9, 16'h10C8, 16'h10C9, 1'b0, 16'h0001};
    vt[2] = '{2, 3, 16'h0000, 16'h00FF, 16'h00FF, 1'b1, 16'h0000};
    vt[3] = '{2, 0, 16'hA5A5, 16'h5A5A, 16'hA5A5, 1'b0, 16'hFFFF};
    vt[4] = '{1, 1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000};
    vt[5] = '{1, 2, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 16'hFFFF};
    vt[6] = '{1, 0, 16'h8001, 16'h8001, 16'h8001, 1'b1, 16'h0000};

    drive(1, 1'b0, '0);
    drive(2, 1'b0, '0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stim", 32'(bus2.stim), 0);
    chk("rst_busy", 32'(bus2.busy), 0);
    chk("rst_done", 32'(bus2.done), 0);
    chk("rst_tt", 32'(bus2.tt), 0);
    chk("rst_match", 32'(bus2.match), 0);
    chk("rst_diff", 32'(bus2.diff), 0);
    chk("rst_tt1", 32'(bus1.tt), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      if (vt[i].s == 1) begin
        mode1 = vt[i].mode;
        gt1   = vt[i].gt;
      end else begin
        mode2 = vt[i].mode;
        gt2   = vt[i].gt;
      end
      sweep(vt[i].s, vt[i].exp, da, dc, er);
      chk($sformatf("v%0d_done_at", i), 32'(da), 32'(16 * (vt[i].s + 1)));
      chk($sformatf("v%0d_done_cnt", i), 32'(dc), 1);
      chk($sformatf("v%0d_seq_err", i), 32'(er), 0);
      chk($sformatf("v%0d_tt", i), 32'(g_tt(vt[i].s)), 32'(vt[i].tt));
      chk($sformatf("v%0d_match", i), 32'(g_match(vt[i].s)), 32'(vt[i].m));
      chk($sformatf("v%0d_diff", i), 32'(g_diff(vt[i].s)), 32'(vt[i].d));
    end

    // start held high across a whole sweep
    mode2 = 0;
    gt2   = 16'h10C9;
    drive(2, 1'b1, 16'h10C9);
    @(posedge clk); #1;
    dn = 0; da = -1; b49 = 1'b1; b50 = 1'b0; s50 = 4'hF;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (bus2.done === 1'b1) begin
        dn++;
        if (da < 0) da = k;
      end
      if (k == 49) b49 = bus2.busy;
      if (k == 50) begin
        b50 = bus2.busy;
        s50 = bus2.stim;
      end
    end
    chk("held_done_cnt", 32'(dn), 1);
    chk("held_done_at", 32'(da), 48);
    chk("held_busy49", 32'(b49), 0);
    chk("held_busy50", 32'(b50), 1);
    chk("held_stim50", 32'(s50), 0);
    drive(2, 1'b0, 16'h0000);
    da = -1;
    for (int k = 61; k <= 120; k++) begin
      @(posedge clk); #1;
      if (bus2.done === 1'b1 && da < 0) da = k;
    end
    chk("held_second_done_at", 32'(da), 98);
    chk("held_second_tt", 32'(bus2.tt), 32'h10C9);

    // reset in the middle of a sweep
    drive(2, 1'b1, 16'h10C9);
    @(posedge clk); #1;
    drive(2, 1'b0, 16'h0000);
    repeat (19) @(posedge clk);
    #1;
    chk("pre_rst_stim", 32'(bus2.stim), 6);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_stim", 32'(bus2.stim), 0);
    chk("mid_rst_busy", 32'(bus2.busy), 0);
    chk("mid_rst_done", 32'(bus2.done), 0);
    chk("mid_rst_tt", 32'(bus2.tt), 0);
    chk("mid_rst_match", 32'(bus2.match), 0);
    dn = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (bus2.done === 1'b1) dn++;
    end
    chk("mid_rst_no_done", 32'(dn), 0);
    sweep(2, 16'h10C9, da, dc, er);
    chk("fresh_done_at", 32'(da), 48);
    chk("fresh_done_cnt", 32'(dc), 1);
    chk("fresh_seq_err", 32'(er), 0);
    chk("fresh_tt", 32'(bus2.tt), 32'h10C9);
    chk("fresh_match", 32'(bus2.match), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
